// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing FSM for a multi-cycle RISC-V datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives per-state datapath strobes.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [RET_W-1:0]   retired_q;
  logic               illegal_q, bus_err_q;
  logic               retire, set_illegal, set_bus_err;
  logic               wait_active, wait_ready, timeout;

  // Only FETCH, MEM_RD and MEM_WR block on a memory handshake.
  always_comb begin
    wait_active = 1'b0;
    wait_ready  = 1'b0;
    case (state)
      S_FETCH:  begin wait_active = 1'b1; wait_ready = imem_ready; end
      S_MEM_RD,
      S_MEM_WR: begin wait_active = 1'b1; wait_ready = dmem_ready; end
      default:  ;
    endcase
    timeout = (MEM_TIMEOUT != 0) && wait_active && !wait_ready &&
              (wait_cnt == CNT_W'(MEM_TIMEOUT));
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_FETCH:    if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_nxt = S_EXEC_R;
          OP_IMM:             state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
          OP_JAL:             state_nxt = S_JUMP;
          default: begin
            state_nxt   = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:   state_nxt = S_ALU_WB;
      S_ALU_WB:   begin state_nxt = S_FETCH; retire = 1'b1; end
      S_MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (dmem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   begin state_nxt = S_FETCH; retire = 1'b1; end
      S_MEM_WR:   if (dmem_ready) begin state_nxt = S_FETCH; retire = 1'b1; end
      S_BRANCH,
      S_JUMP:     begin state_nxt = S_FETCH; retire = 1'b1; end
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_HALT;
    endcase
    // A ready in the limit cycle already took the normal path above.
    if (timeout) begin
      state_nxt   = S_HALT;
      set_bus_err = 1'b1;
      retire      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (wait_active && !wait_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (retire)      retired_q <= retired_q + RET_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  // Strobes are a state decode, forced low while rst is held so an aborted
  // instruction cannot leak a write in the reset cycle.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    wb_sel     = 2'b00;
    reg_write  = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_en    = imem_ready;
        end
        S_EXEC_R: alu_op = 2'b10;
        S_EXEC_I: begin alu_src = 1'b1; alu_op = 2'b10; end
        S_ALU_WB: begin
          alu_src   = (opcode == OP_IMM);
          alu_op    = 2'b10;
          reg_write = 1'b1;
        end
        S_MEM_ADDR: alu_src = 1'b1;
        S_MEM_RD:   begin dmem_read = 1'b1; alu_src = 1'b1; end
        S_MEM_WB:   begin reg_write = 1'b1; wb_sel = 2'b01; end
        S_MEM_WR:   begin dmem_write = 1'b1; alu_src = 1'b1; end
        S_BRANCH: begin
          alu_op = 2'b01;
          pc_en  = zero;
          pc_src = 2'b01;
        end
        S_JUMP: begin
          pc_en     = 1'b1;
          pc_src    = 2'b10;
          reg_write = 1'b1;
          wb_sel    = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal = !rst && illegal_q;
  assign bus_err = !rst && bus_err_q;
  assign retired = rst ? '0 : retired_q;

endmodule
